// File: rtl/segment_scan_decoder.sv
// Monitors a multiplexed 7-segment display bus and rebuilds per-digit hex values.
// Define SEGMENT_DP_CAPTURE_EN to also capture decimal points on a DP output.
module segment_scan_decoder #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SEGMENT,
    input  logic [7:0] AN,
    input  logic       CLR_ERR,
    output logic [3:0] DIGIT_0,
    output logic [3:0] DIGIT_1,
    output logic [3:0] DIGIT_2,
    output logic [3:0] DIGIT_3,
    output logic [3:0] VALID,
    output logic [3:0] ERR_PATTERN,
    output logic       SCAN_ERR,
    output logic       FRAME_DONE,
    output logic       SCAN_TIMEOUT
`ifdef SEGMENT_DP_CAPTURE_EN
    ,
    output logic [3:0] DP
`endif
);

`ifdef SEGMENT_DP_CAPTURE_EN
    localparam int unsigned SW = 8;
`else
    localparam int unsigned SW = 7;
`endif
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] DIG_MASK = 8'((9'd1 << NUM_DIGITS) - 9'd1);

    logic [SW-1:0] seg_q, seg_p;
    logic [7:0]    an_q, an_p;
    logic [1:0]    prime_q;
    logic [7:0]    st_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic [7:0]    seen_q;
    logic [3:0]    digit_q [4];
    logic [3:0]    valid_q, err_q;
    logic          scan_err_q, frame_done_q, timeout_q;
`ifdef SEGMENT_DP_CAPTURE_EN
    logic [3:0]    dp_q;
`else
    logic          unused_seg_dp;
    assign unused_seg_dp = SEGMENT[7];
`endif

    logic          stable, cap, multi_sel, blank_sel, sel_ok, frame, to_fire;
    logic [7:0]    an_act, seen_set;
    logic [2:0]    sel_idx;
    logic [6:0]    pat;
    logic [4:0]    dec;
    logic [3:0]    err_set;
    logic [TW-1:0] to_next;

    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    // prime_q[1] marks that both seg_q and seg_p hold real samples taken after reset.
    assign stable    = prime_q[1] && (seg_q == seg_p) && (an_q == an_p);
    assign cap       = stable && (st_cnt_q == 8'(SETTLE_CYCLES - 1));
    assign an_act    = ~an_q;
    assign blank_sel = (an_act == 8'd0);
    assign multi_sel = ((an_act & (an_act - 8'd1)) != 8'd0);

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_act[i]) sel_idx = 3'(i);
        end
    end

    assign sel_ok   = cap && !blank_sel && !multi_sel && (32'(sel_idx) < NUM_DIGITS);
    assign pat      = ~seg_q[6:0];
    assign dec      = seg_decode(pat);
    assign err_set  = (sel_ok && !sel_idx[2] && !dec[4] && (pat != 7'd0)) ?
                      (4'd1 << sel_idx[1:0]) : 4'd0;
    assign seen_set = seen_q | (sel_ok ? (8'd1 << sel_idx) : 8'd0);
    assign frame    = sel_ok && ((seen_set & DIG_MASK) == DIG_MASK);
    assign to_next  = (to_cnt_q == TW'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + TW'(1);
    assign to_fire  = !sel_ok && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_q        <= '0;
            seg_p        <= '0;
            an_q         <= '0;
            an_p         <= '0;
            prime_q      <= '0;
            st_cnt_q     <= '0;
            to_cnt_q     <= '0;
            seen_q       <= '0;
            valid_q      <= '0;
            err_q        <= '0;
            scan_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < 4; i++) digit_q[i] <= '0;
`ifdef SEGMENT_DP_CAPTURE_EN
            dp_q         <= '0;
`endif
        end else begin
            seg_q        <= SEGMENT[SW-1:0];
            seg_p        <= seg_q;
            an_q         <= AN;
            an_p         <= an_q;
            prime_q      <= {prime_q[0], 1'b1};
            if (!stable) begin
                st_cnt_q <= '0;
            end else if (st_cnt_q != 8'(SETTLE_CYCLES)) begin
                st_cnt_q <= st_cnt_q + 8'd1;
            end
            scan_err_q   <= cap && multi_sel;
            frame_done_q <= frame;
            err_q        <= (CLR_ERR ? 4'd0 : err_q) | err_set;
            if (sel_ok) begin
                to_cnt_q  <= '0;
                timeout_q <= 1'b0;
                seen_q    <= frame ? 8'd0 : seen_set;
                if (!sel_idx[2]) begin
                    if (dec[4]) begin
                        digit_q[sel_idx[1:0]] <= dec[3:0];
                        valid_q[sel_idx[1:0]] <= 1'b1;
                    end else begin
                        valid_q[sel_idx[1:0]] <= 1'b0;
                    end
`ifdef SEGMENT_DP_CAPTURE_EN
                    dp_q[sel_idx[1:0]] <= ~seg_q[7];
`endif
                end
            end else begin
                to_cnt_q <= to_next;
                if (to_fire) begin
                    timeout_q <= 1'b1;
                    valid_q   <= '0;
                    seen_q    <= '0;
`ifdef SEGMENT_DP_CAPTURE_EN
                    dp_q      <= '0;
`endif
                end
            end
        end
    end

    assign DIGIT_0      = DIG_MASK[0] ? digit_q[0] : 4'd0;
    assign DIGIT_1      = DIG_MASK[1] ? digit_q[1] : 4'd0;
    assign DIGIT_2      = DIG_MASK[2] ? digit_q[2] : 4'd0;
    assign DIGIT_3      = DIG_MASK[3] ? digit_q[3] : 4'd0;
    assign VALID        = valid_q & DIG_MASK[3:0];
    assign ERR_PATTERN  = err_q & DIG_MASK[3:0];
    assign SCAN_ERR     = scan_err_q;
    assign FRAME_DONE   = frame_done_q;
    assign SCAN_TIMEOUT = timeout_q;
`ifdef SEGMENT_DP_CAPTURE_EN
    assign DP           = dp_q & DIG_MASK[3:0];
`endif

endmodule
